// File: rtl/trace_pkg.sv
// Shared types and constants for the PC trace capture unit.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } trace_state_t;

    localparam logic TRACE_RING    = 1'b0;
    localparam logic TRACE_ONESHOT = 1'b1;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port, no array reset.
module trace_ram #(
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [PC_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [PC_WIDTH-1:0]      rdata
);

    logic [PC_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pc_trace_buffer.sv
// Retired-PC trace capture with ring/one-shot modes, stall/self-loop watchdog
// and an oldest-first valid/ready drain port.
module pc_trace_buffer
    import trace_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int DEPTH       = 16,
    parameter int STALL_LIMIT = 200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       mode,
    input  logic                       pc_valid,
    input  logic [PC_WIDTH-1:0]        pc_in,
    output logic                       capturing,
    output logic                       done,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [PC_WIDTH-1:0]        rd_data,
    output logic                       rd_last
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT = SW'(STALL_LIMIT);

    trace_state_t        state;
    logic                mode_q;
    logic                have_last;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       remaining;
    logic [SW-1:0]       stall_cnt;
    logic [PC_WIDTH-1:0] last_pc;
    logic [PC_WIDTH-1:0] ram_rdata;

    logic                wr_en;
    logic                full_hit;
    logic                stall_hit;
    logic [CW-1:0]       count_nxt;
    logic [AW-1:0]       wr_ptr_nxt;
    logic [SW-1:0]       stall_nxt;

    always_comb begin
        wr_en      = (state == CAPTURE) && !arm && pc_valid;
        count_nxt  = count;
        wr_ptr_nxt = wr_ptr;
        stall_nxt  = stall_cnt;
        if (wr_en) begin
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (count != FULL) begin
                count_nxt = count + 1'b1;
            end
            // The very first sample after arm has nothing to repeat.
            stall_nxt = (have_last && pc_in == last_pc) ? stall_cnt + 1'b1 : '0;
        end
        full_hit  = wr_en && (mode_q == TRACE_ONESHOT) && (count_nxt == FULL);
        stall_hit = wr_en && (stall_nxt == LIMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= TRACE_RING;
            have_last <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            stall_cnt <= '0;
            stall     <= 1'b0;
        end else if (arm) begin
            state     <= CAPTURE;
            mode_q    <= mode;
            have_last <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            stall_cnt <= '0;
            stall     <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    count     <= count_nxt;
                    wr_ptr    <= wr_ptr_nxt;
                    stall_cnt <= stall_nxt;
                    if (wr_en) begin
                        have_last <= 1'b1;
                    end
                    if (stall_hit) begin
                        stall <= 1'b1;
                    end
                    if (stop || full_hit || stall_hit) begin
                        state     <= DONE;
                        // A full buffer has wrapped (or just filled), so the oldest entry sits at wr_ptr.
                        rd_ptr    <= (count_nxt == FULL) ? wr_ptr_nxt : '0;
                        remaining <= count_nxt;
                    end
                end
                DONE: begin
                    if (remaining == '0) begin
                        state <= IDLE;
                    end else if (rd_ready) begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == CW'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            last_pc <= pc_in;
        end
    end

    trace_ram #(
        .PC_WIDTH (PC_WIDTH),
        .DEPTH    (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (pc_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign capturing = (state == CAPTURE);
    assign done      = (state == DONE);
    assign rd_valid  = (state == DONE) && (remaining != '0);
    assign rd_last   = rd_valid && (remaining == CW'(1));
    assign rd_data   = rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed scoreboard bench for pc_trace_buffer (PC_WIDTH=32, DEPTH=16, STALL_LIMIT=200).
module tb_pc_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc_in = '0;
    logic        capturing;
    logic        done;
    logic        stall;
    logic [4:0]  count;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_last;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    pc_trace_buffer #(
        .PC_WIDTH    (32),
        .DEPTH       (16),
        .STALL_LIMIT (200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .stop      (stop),
        .mode      (mode),
        .pc_valid  (pc_valid),
        .pc_in     (pc_in),
        .capturing (capturing),
        .done      (done),
        .stall     (stall),
        .count     (count),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm_cap(input logic m);
        arm  = 1'b1;
        mode = m;
        sb.delete();
        step();
        arm = 1'b0;
    endtask

    task automatic feed(input logic [31:0] v, input logic oneshot);
        pc_valid = 1'b1;
        pc_in    = v;
        if (oneshot) begin
            if (sb.size() < 16) sb.push_back(v);
        end else begin
            sb.push_back(v);
            if (sb.size() > 16) void'(sb.pop_front());
        end
        step();
        pc_valid = 1'b0;
    endtask

    task automatic stop_cap();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        logic [31:0] e;
        int n = 0;
        rd_ready = 1'b1;
        while (sb.size() > 0 && n < budget) begin
            chk({tag, "_rd_valid"}, rd_valid, 1'b1);
            if (rd_valid) begin
                e = sb.pop_front();
                chk({tag, "_rd_data"}, rd_data, e);
                chk({tag, "_rd_last"}, rd_last, sb.size() == 0);
            end
            step();
            n++;
        end
        chk({tag, "_drain_left"}, sb.size(), 0);
        rd_ready = 1'b0;
        chk({tag, "_idle_done"}, done, 1'b0);
        chk({tag, "_idle_rd_valid"}, rd_valid, 1'b0);
    endtask

    logic bp_ready [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        // Reset state
        #3;
        chk("rst_capturing", capturing, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_last", rd_last, 1'b0);
        step();
        rst = 1'b1;
        step();

        // Ring mode, 20 samples into 16 entries
        arm_cap(1'b0);
        chk("ring_capturing", capturing, 1'b1);
        chk("ring_count0", count, 0);
        for (int i = 0; i < 20; i++) begin
            feed(32'(i), 1'b0);
            if (i == 0) chk("ring_count1", count, 1);
        end
        stop_cap();
        chk("ring_done", done, 1'b1);
        chk("ring_count", count, 16);
        chk("ring_stall", stall, 1'b0);
        drain("ring", 40);

        // One-shot mode stops itself when full
        arm_cap(1'b1);
        for (int i = 0; i < 20; i++) begin
            feed(32'(i), 1'b1);
            if (i == 14) chk("os_not_done", done, 1'b0);
            if (i == 15) chk("os_done", done, 1'b1);
        end
        chk("os_count", count, 16);
        chk("os_stall", stall, 1'b0);
        drain("os", 40);

        // Stall watchdog on a self-loop PC
        arm_cap(1'b0);
        for (int i = 0; i < 203; i++) begin
            feed((i == 0) ? 32'h40 : (i == 1) ? 32'h44 : 32'h48, 1'b0);
            if (i == 201) chk("stall_not_yet", done, 1'b0);
        end
        chk("stall_done", done, 1'b1);
        chk("stall_flag", stall, 1'b1);
        chk("stall_count", count, 16);
        drain("stall", 40);
        chk("stall_sticky", stall, 1'b1);

        // Backpressure on the drain port
        arm_cap(1'b0);
        chk("bp_stall_cleared", stall, 1'b0);
        feed(32'hA0, 1'b0);
        feed(32'hA4, 1'b0);
        feed(32'hA8, 1'b0);
        stop_cap();
        for (int c = 0; c < 5; c++) begin
            rd_ready = bp_ready[c];
            chk("bp_rd_valid", rd_valid, 1'b1);
            chk("bp_rd_data", rd_data, sb[0]);
            chk("bp_rd_last", rd_last, sb.size() == 1);
            if (bp_ready[c]) void'(sb.pop_front());
            step();
        end
        rd_ready = 1'b0;
        chk("bp_idle", done, 1'b0);
        chk("bp_sb_empty", sb.size(), 0);

        // Re-arm mid-drain, then asynchronous reset mid-capture
        arm_cap(1'b0);
        feed(32'h100, 1'b0);
        feed(32'h104, 1'b0);
        feed(32'h108, 1'b0);
        stop_cap();
        rd_ready = 1'b1;
        chk("rearm_first", rd_data, 32'h100);
        step();
        rd_ready = 1'b0;
        arm_cap(1'b0);
        chk("rearm_count", count, 0);
        chk("rearm_rd_valid", rd_valid, 1'b0);
        chk("rearm_capturing", capturing, 1'b1);
        chk("rearm_done", done, 1'b0);
        feed(32'h200, 1'b0);
        feed(32'h204, 1'b0);
        chk("rearm_count2", count, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_capturing", capturing, 1'b0);
        chk("arst_count", count, 0);
        chk("arst_done", done, 1'b0);
        chk("arst_rd_valid", rd_valid, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("arst_idle", capturing, 1'b0);

        // Empty capture, then simultaneous arm and stop
        arm_cap(1'b0);
        stop_cap();
        chk("empty_done", done, 1'b1);
        chk("empty_rd_valid", rd_valid, 1'b0);
        chk("empty_count", count, 0);
        step();
        chk("empty_idle_done", done, 1'b0);
        chk("empty_idle_cap", capturing, 1'b0);
        arm_cap(1'b0);
        feed(32'h300, 1'b0);
        arm  = 1'b1;
        stop = 1'b1;
        sb.delete();
        step();
        arm  = 1'b0;
        stop = 1'b0;
        chk("armstop_capturing", capturing, 1'b1);
        chk("armstop_done", done, 1'b0);
        chk("armstop_count", count, 0);
        feed(32'h310, 1'b0);
        stop_cap();
        drain("armstop", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
